// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with multi-word lines and a blocking miss FSM.
// Optional hit/miss performance counters are built when DCACHE_PERF_EN is defined.
`ifndef XLEN
`define XLEN 32
`endif

module dcache #(
  parameter int NUM_CACHE_LINES = 4,
  parameter int LINE_WORDS      = 4,
  parameter int ADDR_WIDTH      = `XLEN,
  parameter int DATA_WIDTH      = `XLEN
`ifdef DCACHE_PERF_EN
  ,
  parameter int CNT_WIDTH       = 32
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             mem_req_valid,
  output logic                             mem_req_write,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                             mem_req_ready,
  input  logic                             mem_resp_valid,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_resp_rdata
`ifdef DCACHE_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]             hit_count,
  output logic [CNT_WIDTH-1:0]             miss_count
`endif
);

  localparam int OB     = $clog2(LINE_WORDS);
  localparam int IB     = $clog2(NUM_CACHE_LINES);
  localparam int TAG_W  = ADDR_WIDTH - OB - IB;
  localparam int LINE_W = LINE_WORDS * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_REFILL_REQ,
    S_REFILL_WAIT
  } state_t;

  state_t state_q, state_d;

  logic                  req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;

  logic [NUM_CACHE_LINES-1:0] valid_q;
  logic [NUM_CACHE_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]           tag_q  [NUM_CACHE_LINES];
  logic [LINE_W-1:0]          data_q [NUM_CACHE_LINES];

  logic [OB-1:0]         cur_off;
  logic [IB-1:0]         cur_idx;
  logic [TAG_W-1:0]      cur_tag;
  logic [LINE_W-1:0]     cur_line;
  logic [LINE_W-1:0]     merged_line;
  logic [DATA_WIDTH-1:0] cur_words [LINE_WORDS];
  logic                  hit;
  logic                  victim_dirty;
  logic                  store_hit;
  logic                  refill_done;

  assign cur_off      = req_addr_q[OB-1:0];
  assign cur_idx      = req_addr_q[OB+IB-1:OB];
  assign cur_tag      = req_addr_q[ADDR_WIDTH-1:OB+IB];
  assign cur_line     = data_q[cur_idx];
  assign hit          = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign victim_dirty = valid_q[cur_idx] && dirty_q[cur_idx];
  assign store_hit    = (state_q == S_LOOKUP) && hit && req_write_q;
  assign refill_done  = (state_q == S_REFILL_WAIT) && mem_resp_valid;

  // Split the selected line into words and build the store-merged copy.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign cur_words[gi] = cur_line[gi*DATA_WIDTH +: DATA_WIDTH];
      assign merged_line[gi*DATA_WIDTH +: DATA_WIDTH] =
        (cur_off == OB'(gi)) ? req_wdata_q : cur_line[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit)               state_d = S_IDLE;
        else if (victim_dirty) state_d = S_WB;
        else                   state_d = S_REFILL_REQ;
      end
      S_WB: begin
        if (mem_req_ready) state_d = S_REFILL_REQ;
      end
      S_REFILL_REQ: begin
        if (mem_req_ready) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid) state_d = S_LOOKUP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is gated by state so that reset forces them low at once.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          if (!req_write_q) resp_rdata = cur_words[cur_off];
        end
      end
      S_WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[cur_idx], cur_idx, {OB{1'b0}}};
        mem_req_wdata = cur_line;
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {cur_tag, cur_idx, {OB{1'b0}}};
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      req_write_q <= req_write;
      req_addr_q  <= req_addr;
      req_wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_CACHE_LINES; i++) tag_q[i] <= '0;
    end else if (refill_done) begin
      valid_q[cur_idx] <= 1'b1;
      dirty_q[cur_idx] <= 1'b0;
      tag_q[cur_idx]   <= cur_tag;
    end else if (store_hit) begin
      dirty_q[cur_idx] <= 1'b1;
    end
  end

  // Line data carries no reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_q[cur_idx] <= mem_resp_rdata;
    end else if (store_hit) begin
      data_q[cur_idx] <= merged_line;
    end
  end

`ifdef DCACHE_PERF_EN
  logic                 replay_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q;
  logic [CNT_WIDTH-1:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (refill_done) begin
        replay_q <= 1'b1;
      end else if (state_q == S_LOOKUP) begin
        replay_q <= 1'b0;
      end
      if (state_q == S_LOOKUP && !replay_q) begin
        if (hit) hit_cnt_q  <= hit_cnt_q + 1'b1;
        else     miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Randomized self-checking bench for dcache: a line-level cache/memory model predicts every
// response and memory transfer; directed accesses pin the model with literal values.
`timescale 1ns/1ps

module tb_dcache;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic         req_ready, resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_req_valid, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_req_ready, mem_resp_valid;
  logic [127:0] mem_resp_rdata;
`ifdef DCACHE_PERF_EN
  logic [31:0]  hit_count, miss_count;
  int           m_hits = 0, m_misses = 0;
`endif

  always #5 clk = ~clk;

  dcache dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef DCACHE_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_txn = 0;

  // Model: cache lines and backing memory keyed by line address.
  bit           mv [4];
  bit           md [4];
  logic [27:0]  mt [4];
  logic [127:0] mdat [4];
  logic [127:0] mem_model [logic [31:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_read(input logic [31:0] la);
    logic [127:0] l;
    if (mem_model.exists(la)) return mem_model[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = 32'hC000_0000 | (la << 4) | 32'(w);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
`ifdef DCACHE_PERF_EN
    m_hits = 0;
    m_misses = 0;
`endif
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req_ready"}, req_ready, 1);
    check({nm, "_resp_valid"}, resp_valid, 0);
    check({nm, "_resp_rdata"}, resp_rdata, 0);
    check({nm, "_mem_req_valid"}, mem_req_valid, 0);
    check({nm, "_mem_req_write"}, mem_req_write, 0);
    check({nm, "_mem_req_addr"}, mem_req_addr, 0);
    check({nm, "_mem_req_wdata"}, mem_req_wdata, 0);
`ifdef DCACHE_PERF_EN
    check({nm, "_hit_count"}, hit_count, 0);
    check({nm, "_miss_count"}, miss_count, 0);
`endif
  endtask

  // Entered at the negedge of the first cycle of WB or REFILL_REQ; leaves at the negedge
  // of the first cycle of the following state. Stall cycles inject ignored responses.
  task automatic handshake(input string nm, input bit wr, input logic [31:0] a,
                           input logic [127:0] d, input int stall);
    for (int i = 0; i <= stall; i++) begin
      check({nm, "_valid"}, mem_req_valid, 1);
      check({nm, "_write"}, mem_req_write, wr);
      check({nm, "_addr"}, mem_req_addr, a);
      check({nm, "_wdata"}, mem_req_wdata, d);
      check({nm, "_req_ready"}, req_ready, 0);
      check({nm, "_resp_valid"}, resp_valid, 0);
      if (i == stall) begin
        mem_req_ready = 1'b1;
      end else begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = i[0];
        mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
    end
  endtask

  // Starts and ends at a negedge in IDLE.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int stall, input int rdly, output logic [31:0] rdata_o,
                        output bit hit_o, output bit wb_o, output logic [127:0] wbdata_o);
    logic [27:0]  tg;
    logic [1:0]   ix, of;
    logic [127:0] line;
    logic [31:0]  exp_rd;
    tg = addr[31:4];
    ix = addr[3:2];
    of = addr[1:0];
    wb_o = 1'b0;
    wbdata_o = '0;
    check("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    // Lookup cycle: the held request now carries garbage that must be ignored.
    req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
    hit_o = mv[ix] && (mt[ix] == tg);
`ifdef DCACHE_PERF_EN
    if (hit_o) m_hits++; else m_misses++;
`endif
    check("lookup_req_ready", req_ready, 0);
    if (!hit_o) begin
      check("miss_resp_valid", resp_valid, 0);
      check("miss_mem_idle", mem_req_valid, 0);
      @(negedge clk);
      if (mv[ix] && md[ix]) begin
        wb_o = 1'b1;
        wbdata_o = mdat[ix];
        handshake("wb", 1'b1, {mt[ix], ix, 2'b00}, mdat[ix], stall);
        mem_model[{mt[ix], ix, 2'b00}] = mdat[ix];
      end
      handshake("refill_req", 1'b0, {tg, ix, 2'b00}, '0, stall);
      for (int i = 0; i < rdly; i++) begin
        check("wait_mem_req_valid", mem_req_valid, 0);
        check("wait_resp_valid", resp_valid, 0);
        check("wait_req_ready", req_ready, 0);
        mem_req_ready = i[0];
        @(negedge clk);
        mem_req_ready = 1'b0;
      end
      line = mem_read({tg, ix, 2'b00});
      mem_resp_valid = 1'b1;
      mem_resp_rdata = line;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
      mv[ix] = 1'b1; md[ix] = 1'b0; mt[ix] = tg; mdat[ix] = line;
    end
    exp_rd = wr ? 32'h0 : mdat[ix][of*32 +: 32];
    check("resp_valid", resp_valid, 1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_mem_idle", mem_req_valid, 0);
    rdata_o = resp_rdata;
    if (wr) begin
      mdat[ix][of*32 +: 32] = wd;
      md[ix] = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("done_req_ready", req_ready, 1);
    check("done_resp_valid", resp_valid, 0);
`ifdef DCACHE_PERF_EN
    check("hit_count", hit_count, 32'(m_hits));
    check("miss_count", miss_count, 32'(m_misses));
`endif
    n_txn++;
    $display("txn %0d: %s addr=%h wdata=%h %s%s rdata=%h", n_txn, wr ? "ST" : "LD", addr, wd,
             hit_o ? "hit" : "miss", wb_o ? "+wb" : "", rdata_o);
  endtask

  logic [31:0]  rd;
  bit           h, wb;
  logic [127:0] wbd;

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean miss, load hit, store/load hit, dirty conflict with long backpressure.
    mem_model[32'h10] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    access(0, 32'h10, 0, 0, 2, rd, h, wb, wbd);
    check("t1_rdata", rd, 32'hA0);
    check("t1_miss", h, 0);
    check("t1_no_wb", wb, 0);
    access(0, 32'h13, 0, 1, 0, rd, h, wb, wbd);
    check("t2_rdata", rd, 32'hA3);
    check("t2_hit", h, 1);
    access(1, 32'h11, 32'hDEADBEEF, 0, 0, rd, h, wb, wbd);
    check("t3_store_hit", h, 1);
    check("t3_store_rdata", rd, 0);
    access(0, 32'h11, 0, 0, 0, rd, h, wb, wbd);
    check("t3_load_hit", h, 1);
    check("t3_rdata", rd, 32'hDEADBEEF);
    access(0, 32'h50, 0, 10, 1, rd, h, wb, wbd);
    check("t4_wb", wb, 1);
    check("t4_wbdata", wbd, {32'hA3, 32'hA2, 32'hDEADBEEF, 32'hA0});
    check("t4_rdata", rd, 32'hC000_0500);

    // Asynchronous reset in REFILL_REQ (s=0) and in REFILL_WAIT (s=1).
    for (int s = 0; s < 2; s++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h34;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_pre_mem_req_valid", mem_req_valid, 1);
      if (s == 1) begin
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rst_pre_wait_req_ready", req_ready, 0);
      end
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
    end
    access(0, 32'h13, 0, 0, 0, rd, h, wb, wbd);
    check("t6_miss_after_reset", h, 0);
    check("t6_rdata", rd, 32'hA3);

    // Randomized traffic over a small address space to force conflicts and writebacks.
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), rd, h, wb, wbd);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache with multi-word lines and a blocking miss FSM. It is the parametrised successor of our single-word direct-mapped cache. It sits between the core's memory stage (valid/ready request, one-cycle-pulse response) and the memory arbiter, and moves whole lines over a request/response handshake.

## Interface
- `NUM_CACHE_LINES`, default 4: number of lines; power of 2, ≥2.
- `LINE_WORDS`, default 4: words per line; power of 2, ≥2.
- `ADDR_WIDTH`, default `XLEN`: word-address width.
- `DATA_WIDTH`, default `XLEN`: word width.
- `CNT_WIDTH`, default 32: performance counter width; only with `DCACHE_PERF_EN`.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: core request present.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_WIDTH`: word address.
  - Offset = `[OB-1:0]`, index = `[OB+IB-1:OB]`, tag = the remaining upper bits.
  - OB = clog2(`LINE_WORDS`), IB = clog2(`NUM_CACHE_LINES`).
- `req_wdata` in `DATA_WIDTH`: store data.
- `req_ready` out 1: high only in IDLE.
- `resp_valid` out 1: one-cycle pulse; access complete.
- `resp_rdata` out `DATA_WIDTH`: load data; valid with `resp_valid` on loads, 0 on stores.
- `mem_req_valid` out 1: line transfer request.
- `mem_req_write` out 1: 1 = writeback, 0 = refill.
- `mem_req_addr` out `ADDR_WIDTH`: line-aligned word address (offset bits 0).
- `mem_req_wdata` out `LINE_WORDS*DATA_WIDTH`: victim line; word 0 in the LSBs.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: refill data present.
- `mem_resp_rdata` in `LINE_WORDS*DATA_WIDTH`: refill line; word 0 in the LSBs.
- `hit_count`, `miss_count` out `CNT_WIDTH`: present only with `DCACHE_PERF_EN`.

## Operation
- **Per-line state:** valid, dirty, tag, `LINE_WORDS` data words. Data is not reset.
- **IDLE:** `req_ready`=1. On `req_valid`, capture write, addr and wdata; go to LOOKUP. Later changes on the req_* inputs are ignored.
- **LOOKUP:** hit = valid & (stored tag == captured tag).
  - Load hit: `resp_valid`=1, `resp_rdata` = the word at the captured offset; go to IDLE.
  - Store hit: write the word, set dirty, `resp_valid`=1; go to IDLE.
  - Miss on a valid and dirty line: go to WB.
  - Miss otherwise: go to REFILL_REQ.
- **WB:** `mem_req_valid`=1, `mem_req_write`=1, `mem_req_addr`={old tag, index, 0}, `mem_req_wdata`=victim line. Outputs are held stable until `mem_req_ready`; then go to REFILL_REQ.
- **REFILL_REQ:** `mem_req_valid`=1, `mem_req_write`=0, `mem_req_addr`={tag, index, 0}. Held until `mem_req_ready`; then go to REFILL_WAIT.
- **REFILL_WAIT:** wait for `mem_resp_valid`. Then install the line with valid=1, dirty=0 and the new tag, and go to LOOKUP (replay). The replay always hits; a store replay merges its word and sets dirty.
- **Boundary rules:**
  - `mem_resp_valid` outside REFILL_WAIT is ignored.
  - `mem_req_ready` while `mem_req_valid`=0 is ignored.
  - `req_valid` while `req_ready`=0 is ignored; the requester must hold the request.
  - A line's index wraps naturally; no aliasing between different tags.

## Timing
- **Reset values:** all outputs 0 except `req_ready`=1; state IDLE; all valid and dirty bits 0; counters 0.
- **Reset mid-transfer:** the transfer is abandoned; `mem_req_valid` drops immediately (asynchronous).
- **Hit latency:** accept in cycle T; `resp_valid` in cycle T+1; `req_ready` again in T+2. Peak throughput is one access per 2 cycles.
- **Clean miss:** T+1 LOOKUP, T+2 REFILL_REQ. If `mem_resp_valid` arrives in cycle R, the replay LOOKUP occurs in R+1, and `resp_valid` is asserted in R+1.
- **Dirty miss:** one extra handshake (WB) before REFILL_REQ; at least 1 extra cycle.

## Configuration
- **`DCACHE_PERF_EN` defined:**
  - `hit_count` increments on each first-attempt LOOKUP hit.
  - `miss_count` increments on each first-attempt LOOKUP miss.
  - Replay LOOKUPs are not counted.
  - Counters wrap modulo 2^`CNT_WIDTH` and are cleared by `rst`.
- **`DCACHE_PERF_EN` not defined:** the ports and counter logic are absent; all other behaviour is identical.

## Test plan
Defaults throughout: 4 lines, 4 words, 32-bit. Offset is `[1:0]`, index is `[3:2]`.

1. **Clean miss:** after reset, load 0x10.
   - Required: REFILL_REQ with `mem_req_addr`=0x10 and `mem_req_write`=0; no WB.
   - Return words {0xA0,0xA1,0xA2,0xA3}. Required: `resp_rdata`=0xA0 one cycle after `mem_resp_valid`; `miss_count`=1.
2. **Load hit:** load 0x13.
   - Required: `resp_valid` at T+1 with 0xA3; no memory traffic; `hit_count`=1.
3. **Store hit then load:** store 0xDEADBEEF to 0x11, then load 0x11.
   - Required: both hit; load returns 0xDEADBEEF; no memory traffic.
4. **Dirty conflict miss:** load 0x50 (same index 0, tag 5).
   - Required: WB to 0x10 with word 1 = 0xDEADBEEF and words 0/2/3 = 0xA0/0xA2/0xA3.
   - Then REFILL_REQ to 0x50; load returns the refilled word 0.
5. **Memory backpressure:** hold `mem_req_ready`=0 for 10 cycles during WB.
   - Required: `mem_req_valid`, addr and wdata stable; `req_ready`=0 throughout; a spurious `mem_resp_valid` is ignored.
6. **Reset mid-refill:** assert `rst` in REFILL_WAIT.
   - Required: outputs drop to reset values immediately.
   - Afterwards, load 0x13 misses (valid cleared).
